// File: rtl/rom_boot_loader_pkg.sv
// Shared constants and state encodings for the UART ROM boot loader.
package rom_boot_loader_pkg;

   localparam logic [7:0] BOOT_MAGIC  = 8'hA5;
   localparam logic       RST_ENABLE  = 1'b1;
   localparam logic       RST_DISABLE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } boot_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/rom_boot_loader_uart_rx_byte.sv
// 8N1 UART byte receiver; byte_valid ~9.5 bit times + 2 cycles after the start edge.
// No backpressure: byte_valid/frame_err are single-cycle pulses that must be consumed at once.
module uart_rx_byte
   import rom_boot_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic       frame_err,
   output logic [7:0] data
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic            rx_s1, rx_s2, rx_prev;
   rx_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            bv_d, fe_d;

   // rx_prev gives edge detection, so a stop bit held low cannot retrigger a start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      bv_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev && !rx_s2) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s2, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               bv_d    = 1'b1;
               fe_d    = !rx_s2;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_valid <= bv_d;
         frame_err  <= fe_d;
      end
   end

   assign data = shift_q;

endmodule

// File: rtl/rom_boot_loader.sv
// UART boot loader: writes a checksummed image into the ROM and holds the core in reset until it lands.
// rom_we one cycle after the 4th byte of a word; no backpressure, ROM must accept every write.
module rom_boot_loader
   import rom_boot_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [31:0]       rom_wdata,
   output logic              cpu_rst,
   output logic              boot_done,
   output logic              boot_err
);

   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

   logic        rx_vld, rx_ferr;
   logic [7:0]  rx_dat;
   logic        byte_ok, start_frame, word_done;
   boot_state_t state_q, state_d;
   logic [7:0]  len_lo_q;
   logic [15:0] words_left_q;
   logic [1:0]  byte_idx_q;
   logic [23:0] word_q;
   logic [7:0]  csum_q;
   logic [16:0] len_full;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (uart_rx),
      .byte_valid (rx_vld),
      .frame_err  (rx_ferr),
      .data       (rx_dat)
   );

   assign byte_ok  = rx_vld && !rx_ferr;
   assign len_full = {1'b0, rx_dat, len_lo_q};

   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      word_done   = 1'b0;
      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (byte_ok && rx_dat == BOOT_MAGIC) begin
               state_d     = ST_LEN0;
               start_frame = 1'b1;
            end
         end
         ST_LEN0: if (byte_ok) state_d = ST_LEN1;
         ST_LEN1: begin
            if (byte_ok) begin
               if (len_full == 17'd0)         state_d = ST_CSUM;
               else if (len_full > CAPACITY)  state_d = ST_ERR;
               else                           state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (byte_ok && byte_idx_q == 2'd3) begin
               word_done = 1'b1;
               if (words_left_q == 16'd1) state_d = ST_CSUM;
            end
         end
         ST_CSUM: if (byte_ok) state_d = (rx_dat == csum_q) ? ST_DONE : ST_ERR;
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
      // A framing error mid-image aborts the load; byte_ok already blocks datapath updates.
      if (rx_ferr && state_q != ST_IDLE && state_q != ST_DONE) begin
         state_d     = ST_ERR;
         start_frame = 1'b0;
         word_done   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         rom_we       <= 1'b0;
         rom_addr     <= '0;
         rom_wdata    <= 32'd0;
         len_lo_q     <= 8'd0;
         words_left_q <= 16'd0;
         byte_idx_q   <= 2'd0;
         word_q       <= 24'd0;
         csum_q       <= 8'd0;
      end else begin
         rom_we <= word_done;
         if (word_done) rom_wdata <= {rx_dat, word_q};
         if (start_frame) begin
            rom_addr   <= '0;
            byte_idx_q <= 2'd0;
            csum_q     <= 8'd0;
         end else begin
            if (rom_we) rom_addr <= rom_addr + 1'b1;
            if (state_q == ST_DATA && byte_ok) begin
               csum_q     <= csum_q ^ rx_dat;
               byte_idx_q <= byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0:    word_q[7:0]   <= rx_dat;
                  2'd1:    word_q[15:8]  <= rx_dat;
                  2'd2:    word_q[23:16] <= rx_dat;
                  default: words_left_q  <= words_left_q - 16'd1;
               endcase
            end
         end
         if (state_q == ST_LEN0 && byte_ok) len_lo_q <= rx_dat;
         if (state_q == ST_LEN1 && byte_ok) words_left_q <= {rx_dat, len_lo_q};
      end
   end

   assign cpu_rst   = (state_q != ST_DONE);
   assign boot_done = (state_q == ST_DONE);
   assign boot_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench: frames driven bit-by-bit on uart_rx, ROM writes checked by a queue-based monitor.
module tb_rom_boot_loader;

   localparam int CPB = 8;
   localparam int AW  = 4;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          uart_rx = 1'b1;
   logic          rom_we;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_wdata;
   logic          cpu_rst, boot_done, boot_err;

   int  n_checks = 0;
   int  n_fail   = 0;
   wr_t exp_q[$];

   rom_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .rom_we    (rom_we),
      .rom_addr  (rom_addr),
      .rom_wdata (rom_wdata),
      .cpu_rst   (cpu_rst),
      .boot_done (boot_done),
      .boot_err  (boot_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_bytes(input bq_t q);
      foreach (q[i]) send_byte(q[i], 1'b1);
   endtask

   task automatic push_good_writes();
      exp_q.push_back('{addr: 4'd0, data: 32'h0050_0013});
      exp_q.push_back('{addr: 4'd1, data: 32'h0010_0093});
   endtask

   task automatic check_status(input string tag, input logic done, input logic err, input logic crst);
      check({tag, "_boot_done"}, 32'(boot_done), 32'(done));
      check({tag, "_boot_err"},  32'(boot_err),  32'(err));
      check({tag, "_cpu_rst"},   32'(cpu_rst),   32'(crst));
   endtask

   task automatic do_reset(input string tag);
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Monitor: pops expected writes and checks done timing relative to the receiver strobe.
   initial begin
      logic we_prev, done_prev, bv_prev;
      wr_t  e;
      we_prev = 1'b0; done_prev = 1'b0; bv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rom_we) begin
               check("we_not_back_to_back", 32'(we_prev), 32'd0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", rom_addr, rom_wdata);
               end else begin
                  e = exp_q.pop_front();
                  check("write_addr", 32'(rom_addr), 32'(e.addr));
                  check("write_data", rom_wdata, e.data);
               end
            end
            if (boot_done && !done_prev)
               check("done_one_cycle_after_byte", 32'(bv_prev), 32'd1);
         end
         we_prev   = rom_we;
         done_prev = boot_done;
         bv_prev   = u_dut.u_rx.byte_valid;
      end
   end

   initial begin
      bq_t good_frame, bad_frame;
      good_frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
      bad_frame  = good_frame;
      bad_frame[11] = 8'hC1;

      repeat (3) @(negedge clk);
      check("reset_rom_we",    32'(rom_we),    32'd0);
      check("reset_rom_addr",  32'(rom_addr),  32'd0);
      check("reset_rom_wdata", rom_wdata,      32'd0);
      check_status("reset", 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Good two-word image
      push_good_writes();
      send_bytes(good_frame);
      check_status("good", 1'b1, 1'b0, 1'b0);
      send_byte(8'hA5, 1'b1);
      check_status("done_sticky", 1'b1, 1'b0, 1'b0);
      do_reset("good");

      // Bad checksum, then a clean retry from ERR
      push_good_writes();
      send_bytes(bad_frame);
      check_status("bad_csum", 1'b0, 1'b1, 1'b1);
      push_good_writes();
      send_bytes(good_frame);
      check_status("retry", 1'b1, 1'b0, 1'b0);
      do_reset("retry");

      // Empty image
      send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
      check_status("empty", 1'b1, 1'b0, 1'b0);
      do_reset("empty");

      // Oversized length: 17 words into a 16-word ROM
      send_bytes('{8'hA5, 8'h11, 8'h00});
      check_status("too_long", 1'b0, 1'b1, 1'b1);
      do_reset("too_long");

      // Junk bytes and a short glitch before a valid frame
      send_bytes('{8'h3C, 8'hFF});
      check_status("junk", 1'b0, 1'b0, 1'b1);
      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      uart_rx = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      push_good_writes();
      send_bytes(good_frame);
      check_status("after_junk", 1'b1, 1'b0, 1'b0);
      do_reset("after_junk");

      // Framing error on the third data byte
      send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00});
      send_byte(8'h50, 1'b0);
      check_status("frame_err", 1'b0, 1'b1, 1'b1);
      send_byte(8'h00, 1'b1);
      check_status("frame_err_hold", 1'b0, 1'b1, 1'b1);
      do_reset("frame_err");

      // Reset asserted mid-DATA after one word has landed
      exp_q.push_back('{addr: 4'd0, data: 32'h0050_0013});
      send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00});
      check("mid_rom_addr",  32'(rom_addr), 32'd1);
      check("mid_rom_wdata", rom_wdata,     32'h0050_0013);
      check("mid_pending",   32'(exp_q.size()), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rom_we",    32'(rom_we),   32'd0);
      check("async_rom_addr",  32'(rom_addr), 32'd0);
      check("async_rom_wdata", rom_wdata,     32'd0);
      check_status("async", 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
